main_comparator_strait: RTL and testbench

Final-stage response checker for the STRAIT BIST datapath. Every clock cycle it compares the accumulator output of the circuit under test against the golden expected value. Any mismatch sets a sticky `ERROR` flag that stays high until reset. It sits at the end of the BIST chain and is the block's single pass/fail indicator.

---
 rtl/strait_bist_pkg.sv | 15 +
 rtl/strait_fail_capture.sv | 44 ++++
 rtl/main_comparator_strait.sv | 61 ++++++
 tb/tb_main_comparator_strait.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/strait_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : strait_bist_pkg
// Purpose  : Shared widths and word type for the STRAIT BIST datapath.
// Revision : 1.0 - initial release
// ============================================================================
package strait_bist_pkg;

    localparam int STRAIT_WORD_W    = 32;
    localparam int STRAIT_FAILCNT_W = 16;

    typedef logic [STRAIT_WORD_W-1:0] strait_word_t;

endpackage
`default_nettype wire

// File: rtl/strait_fail_capture.sv
`default_nettype none
// ============================================================================
// Module   : strait_fail_capture
// Purpose  : Saturating mismatch counter plus first-failure word capture.
// Revision : 1.0 - initial release
// ============================================================================
module strait_fail_capture
    import strait_bist_pkg::*;
#(
    parameter int WIDTH = STRAIT_WORD_W,
    parameter int CNT_W = STRAIT_FAILCNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mismatch,
    input  logic             error_q,
    input  logic [WIDTH-1:0] accum_out,
    input  logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] fail_count,
    output logic [WIDTH-1:0] first_actual,
    output logic [WIDTH-1:0] first_expected
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            fail_count     <= '0;
            first_actual   <= '0;
            first_expected <= '0;
        end else if (mismatch) begin
            if (fail_count != C_CNT_MAX) begin
                fail_count <= fail_count + 1'b1;
            end
            // The sticky flag still low means this is the first failure since reset.
            if (!error_q) begin
                first_actual   <= accum_out;
                first_expected <= expected;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_comparator_strait.sv
`default_nettype none
// ============================================================================
// Module   : main_comparator_strait
// Purpose  : Final BIST response checker; sticky ERROR on any word mismatch.
//            Define MAIN_COMPARATOR_STRAIT_DIAG_EN for fail count/capture ports.
// Revision : 1.0 - initial release
// ============================================================================
module main_comparator_strait
    import strait_bist_pkg::*;
#(
    parameter int WIDTH = STRAIT_WORD_W
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
    ,
    parameter int CNT_W = STRAIT_FAILCNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] accum_out,
    input  logic [WIDTH-1:0] expected,
    output logic             ERROR
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
    ,
    output logic [CNT_W-1:0] fail_count,
    output logic [WIDTH-1:0] first_actual,
    output logic [WIDTH-1:0] first_expected
`endif
);

    logic w_mismatch;

    // X/Z inputs leave the inequality non-1, so the flag simply holds.
    assign w_mismatch = (accum_out != expected);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ERROR <= 1'b0;
        end else if (w_mismatch) begin
            ERROR <= 1'b1;
        end
    end

`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
    strait_fail_capture #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_fail_capture (
        .clk            (clk),
        .rst            (rst),
        .mismatch       (w_mismatch),
        .error_q        (ERROR),
        .accum_out      (accum_out),
        .expected       (expected),
        .fail_count     (fail_count),
        .first_actual   (first_actual),
        .first_expected (first_expected)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_comparator_strait.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_comparator_strait
// Purpose  : Self-checking bench for main_comparator_strait (both builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_comparator_strait;

    localparam int W     = 32;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  accum_out = '0;
    logic [W-1:0]  expected  = '0;
    logic          ERROR;
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
    logic [CW-1:0] fail_count;
    logic [W-1:0]  first_actual;
    logic [W-1:0]  first_expected;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state derived directly from the behavioural rules.
    bit           m_err;
    int           m_cnt;
    logic [W-1:0] m_fa;
    logic [W-1:0] m_fe;

    always #5 clk = ~clk;

    main_comparator_strait dut (
        .clk            (clk),
        .rst            (rst),
        .accum_out      (accum_out),
        .expected       (expected),
        .ERROR          (ERROR)
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
        ,
        .fail_count     (fail_count),
        .first_actual   (first_actual),
        .first_expected (first_expected)
`endif
    );

    // Apply one clock edge with the given inputs and advance the model.
    task automatic cycle(input logic [W-1:0] a, input logic [W-1:0] e, input logic r);
        accum_out = a;
        expected  = e;
        rst       = r;
        @(posedge clk);
        #1;
        if (!r) begin
            m_err = 0; m_cnt = 0; m_fa = '0; m_fe = '0;
        end else if (a != e) begin
            if (!m_err) begin
                m_fa = a;
                m_fe = e;
            end
            m_err = 1;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic test_reset();
        cycle(32'd1, 32'd2, 1'b0);
        cycle(32'd1, 32'd2, 1'b0);
        checks++;
        if (ERROR !== 1'b0) begin
            failures++; $display("FAIL reset_error: got %0b want 0", ERROR);
        end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
        checks++;
        if (fail_count !== '0 || first_actual !== '0 || first_expected !== '0) begin
            failures++;
            $display("FAIL reset_diag: got cnt=%0h fa=%0h fe=%0h want all 0",
                     fail_count, first_actual, first_expected);
        end
`endif
    endtask

    task automatic test_match();
        cycle(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        checks++;
        if (ERROR !== 1'b0) begin
            failures++; $display("FAIL match_error: got %0b want 0", ERROR);
        end
    endtask

    task automatic test_no_comb_path();
        accum_out = 32'h0000_0001;
        expected  = 32'h8000_0000;
        #2;
        checks++;
        if (ERROR !== 1'b0) begin
            failures++; $display("FAIL comb_path: got %0b want 0 before edge", ERROR);
        end
    endtask

    task automatic test_mismatch();
        cycle(32'hABCD1234, 32'h1234ABCD, 1'b1);
        checks++;
        if (ERROR !== 1'b1) begin
            failures++; $display("FAIL mismatch_error: got %0b want 1", ERROR);
        end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
        checks++;
        if (fail_count !== 16'd1 || first_actual !== 32'hABCD1234 || first_expected !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL mismatch_diag: got cnt=%0h fa=%0h fe=%0h want 1 abcd1234 1234abcd",
                     fail_count, first_actual, first_expected);
        end
`endif
    endtask

    task automatic test_persistence();
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0, 32'h0, 1'b1);
            checks++;
            if (ERROR !== 1'b1) begin
                failures++; $display("FAIL persist_error: cycle %0d got %0b want 1", i, ERROR);
            end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
            checks++;
            if (fail_count !== 16'd1 || first_actual !== 32'hABCD1234 || first_expected !== 32'h1234ABCD) begin
                failures++;
                $display("FAIL persist_diag: got cnt=%0h fa=%0h fe=%0h want 1 abcd1234 1234abcd",
                         fail_count, first_actual, first_expected);
            end
`endif
        end
    endtask

    task automatic test_second_failure();
        cycle(32'd5, 32'd6, 1'b1);
        checks++;
        if (ERROR !== 1'b1) begin
            failures++; $display("FAIL second_error: got %0b want 1", ERROR);
        end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
        checks++;
        if (fail_count !== 16'd2 || first_actual !== 32'hABCD1234 || first_expected !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL second_diag: got cnt=%0h fa=%0h fe=%0h want 2 abcd1234 1234abcd",
                     fail_count, first_actual, first_expected);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        // Mismatching inputs during reset: reset must win.
        cycle(32'h1111_0000, 32'h0000_1111, 1'b0);
        checks++;
        if (ERROR !== 1'b0) begin
            failures++; $display("FAIL midrun_reset_error: got %0b want 0", ERROR);
        end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
        checks++;
        if (fail_count !== '0 || first_actual !== '0 || first_expected !== '0) begin
            failures++;
            $display("FAIL midrun_reset_diag: got cnt=%0h fa=%0h fe=%0h want all 0",
                     fail_count, first_actual, first_expected);
        end
`endif
    endtask

    task automatic test_saturation();
        logic [W-1:0] a0, e0, a, e;
        a0 = $urandom;
        e0 = a0 ^ (32'h1 << $urandom_range(31, 0));
        // First edge after release with a mismatch sets ERROR right away.
        cycle(a0, e0, 1'b1);
        checks++;
        if (ERROR !== 1'b1) begin
            failures++; $display("FAIL first_after_release: got %0b want 1", ERROR);
        end
        for (int i = 1; i < 65537; i++) begin
            a = $urandom;
            e = ~a;
            cycle(a, e, 1'b1);
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
            if (i == 65534) begin
                checks++;
                if (fail_count !== 16'hFFFF) begin
                    failures++; $display("FAIL sat_reach: got %0h want ffff", fail_count);
                end
            end
`endif
        end
        checks++;
        if (ERROR !== 1'b1) begin
            failures++; $display("FAIL sat_error: got %0b want 1", ERROR);
        end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
        checks++;
        if (fail_count !== 16'(m_cnt) || fail_count !== 16'hFFFF) begin
            failures++; $display("FAIL sat_count: got %0h want ffff", fail_count);
        end
        checks++;
        if (first_actual !== a0 || first_expected !== e0) begin
            failures++;
            $display("FAIL sat_capture: got fa=%0h fe=%0h want %0h %0h",
                     first_actual, first_expected, a0, e0);
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, e;
        logic         r;
        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            e = a;
            r = ($urandom_range(39, 0) != 0);
            if ($urandom_range(24, 0) == 0) e = a ^ $urandom_range(32'hFFFF_FFFF, 1);
            cycle(a, e, r);
            checks++;
            if (ERROR !== m_err) begin
                failures++; $display("FAIL rand_error: cycle %0d got %0b want %0b", i, ERROR, m_err);
            end
`ifdef MAIN_COMPARATOR_STRAIT_DIAG_EN
            checks++;
            if (fail_count !== 16'(m_cnt) || first_actual !== m_fa || first_expected !== m_fe) begin
                failures++;
                $display("FAIL rand_diag: cycle %0d got cnt=%0h fa=%0h fe=%0h want %0h %0h %0h",
                         i, fail_count, first_actual, first_expected, m_cnt, m_fa, m_fe);
            end
`endif
        end
    endtask

    initial begin
        m_err = 0; m_cnt = 0; m_fa = '0; m_fe = '0;
        test_reset();
        test_match();
        test_no_comb_path();
        test_mismatch();
        test_persistence();
        test_second_failure();
        test_reset_midrun();
        test_saturation();
        cycle(32'h0, 32'h0, 1'b0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
